// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: ASCII constants, error
// codes, FSM state encodings and small helpers.
package uart_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_L_UP = 8'h4C;
  localparam logic [7:0] ASCII_L_LO = 8'h6C;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_F_UP = 8'h46;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_F_LO = 8'h66;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_OP   = 3'd1,
    ERR_BAD_ARG  = 3'd2,
    ERR_TOO_LONG = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_code_e;

  typedef enum logic {
    F_IDLE,
    F_CAP
  } fetch_state_e;

  typedef enum logic [2:0] {
    P_OP,
    P_ARG,
    P_CR,
    P_DISPATCH,
    P_DISCARD
  } parse_state_e;

  typedef enum logic {
    OP_LED,
    OP_MSG
  } op_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit nibble.
module hex_ascii_decode
  import uart_cmd_parser_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = '0;
    if ((ascii >= ASCII_0) && (ascii <= ASCII_9)) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if (((ascii >= ASCII_A_UP) && (ascii <= ASCII_F_UP)) ||
                 ((ascii >= ASCII_A_LO) && (ascii <= ASCII_F_LO))) begin
      // low nibble of 'A'/'a' is 1, so +9 maps A..F onto 10..15
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Terminal command parser behind the UART RX FIFO: pops bytes, parses
// CR-terminated L<hex>/M<hex> lines, emits command/error pulses and counters.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rf_empty,
  input  logic [7:0] rd_data,
  output logic       rd_stb,
  output logic       led_valid,
  output logic [3:0] led_val,
  output logic       msg_valid,
  output logic [3:0] msg_sel,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic [7:0] cmd_count,
  output logic [7:0] err_count
);

  fetch_state_e fetch_q;
  parse_state_e parse_q;
  op_e          op_q;
  logic [3:0]   arg_q;
  logic [31:0]  timer_q;

  logic         cap;
  logic         waiting;
  logic         expire;
  logic         is_hex;
  logic [3:0]   nibble;
  logic         is_cr;
  logic         is_lf;
  logic         is_l;
  logic         is_m;
  logic         err_raise;
  err_code_e    err_kind;

  // The pop is a Mealy output of F_IDLE and the byte is consumed straight
  // off rd_data in F_CAP, so a CR popped in cycle N dispatches in N+2.
  assign rd_stb = rst_n && (fetch_q == F_IDLE) && !rf_empty;
  assign cap    = (fetch_q == F_CAP);

  assign is_cr = (rd_data == ASCII_CR);
  assign is_lf = (rd_data == ASCII_LF);
  assign is_l  = (rd_data == ASCII_L_UP) || (rd_data == ASCII_L_LO);
  assign is_m  = (rd_data == ASCII_M_UP) || (rd_data == ASCII_M_LO);

  assign waiting = (parse_q == P_ARG) || (parse_q == P_CR) || (parse_q == P_DISCARD);
  assign expire  = (TIMEOUT_CYCLES != '0) && (timer_q == TIMEOUT_CYCLES - 32'd1);

  hex_ascii_decode u_hex (
    .ascii  (rd_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_q <= F_IDLE;
    end else begin
      case (fetch_q)
        F_IDLE:  if (!rf_empty) fetch_q <= F_CAP;
        F_CAP:   fetch_q <= F_IDLE;
        default: fetch_q <= F_IDLE;
      endcase
    end
  end

  // A captured byte always pre-empts a timer expiry in the same cycle.
  always_comb begin
    err_raise = 1'b0;
    err_kind  = ERR_NONE;
    if (cap) begin
      if (!is_lf) begin
        case (parse_q)
          P_OP: begin
            if (!is_l && !is_m && !is_cr) begin
              err_raise = 1'b1;
              err_kind  = ERR_BAD_OP;
            end
          end
          P_ARG: begin
            if (!is_hex) begin
              err_raise = 1'b1;
              err_kind  = ERR_BAD_ARG;
            end
          end
          P_CR: begin
            if (!is_cr) begin
              err_raise = 1'b1;
              err_kind  = ERR_TOO_LONG;
            end
          end
          default: ;
        endcase
      end
    end else if (waiting && expire) begin
      err_raise = 1'b1;
      err_kind  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parse_q   <= P_OP;
      op_q      <= OP_LED;
      arg_q     <= '0;
      timer_q   <= '0;
      led_valid <= 1'b0;
      led_val   <= '0;
      msg_valid <= 1'b0;
      msg_sel   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      cmd_count <= '0;
      err_count <= '0;
    end else begin
      led_valid <= 1'b0;
      msg_valid <= 1'b0;
      err_pulse <= err_raise;
      if (err_raise) begin
        err_code  <= err_kind;
        err_count <= sat_inc8(err_count);
      end

      if (cap || !waiting || expire) timer_q <= '0;
      else                           timer_q <= timer_q + 32'd1;

      if (parse_q == P_DISPATCH) begin
        if (op_q == OP_LED) begin
          led_val   <= arg_q;
          led_valid <= 1'b1;
        end else begin
          msg_sel   <= arg_q;
          msg_valid <= 1'b1;
        end
        cmd_count <= cmd_count + 8'd1;
        parse_q   <= P_OP;
      end else if (cap) begin
        if (!is_lf) begin
          case (parse_q)
            P_OP: begin
              if (is_l) begin
                op_q    <= OP_LED;
                parse_q <= P_ARG;
              end else if (is_m) begin
                op_q    <= OP_MSG;
                parse_q <= P_ARG;
              end else if (!is_cr) begin
                parse_q <= P_DISCARD;
              end
            end
            P_ARG: begin
              if (is_hex) begin
                arg_q   <= nibble;
                parse_q <= P_CR;
              end else if (is_cr) begin
                parse_q <= P_OP;
              end else begin
                parse_q <= P_DISCARD;
              end
            end
            P_CR:      parse_q <= is_cr ? P_DISPATCH : P_DISCARD;
            P_DISCARD: if (is_cr) parse_q <= P_OP;
            default:   parse_q <= P_OP;
          endcase
        end
      end else if (waiting && expire) begin
        parse_q <= P_OP;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a FIFO model feeds bytes, expected
// pulses are queued at stimulus time and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam int K_LED = 0;
  localparam int K_MSG = 1;
  localparam int K_ERR = 2;
  localparam int E_BAD_OP   = 1;
  localparam int E_BAD_ARG  = 2;
  localparam int E_TOO_LONG = 3;
  localparam int E_TIMEOUT  = 4;

  logic       clk;
  logic       rst_n;
  logic       rf_empty;
  logic [7:0] rd_data;
  logic       rd_stb;
  logic       led_valid;
  logic [3:0] led_val;
  logic       msg_valid;
  logic [3:0] msg_sel;
  logic       err_pulse;
  logic [2:0] err_code;
  logic [7:0] cmd_count;
  logic [7:0] err_count;

  typedef struct {
    int kind;
    int val;
    int cmd;
    int err;
    int ref_idx;
    int lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         stb_cyc [0:4095];
  int         cyc = 0;
  int         n_pushed = 0;
  int         pop_count = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_cmd = 0;
  int         exp_err = 0;
  int         last_led = 0;
  int         last_msg = 0;
  int         last_code = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(32'd20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rf_empty  (rf_empty),
    .rd_data   (rd_data),
    .rd_stb    (rd_stb),
    .led_valid (led_valid),
    .led_val   (led_val),
    .msg_valid (msg_valid),
    .msg_sel   (msg_sel),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .cmd_count (cmd_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [7:0] hex_char(input int v, input bit lower);
    logic [7:0] c;
    if (v < 10) c = 8'h30 + 8'(v);
    else        c = (lower ? 8'h61 : 8'h41) + 8'(v - 10);
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    n_pushed++;
  endtask

  task automatic exp_push(input int kind, input int val, input int ref_idx, input int lat);
    exp_t e;
    if (kind == K_ERR) begin
      exp_err   = (exp_err == 255) ? 255 : exp_err + 1;
      last_code = val;
    end else begin
      exp_cmd = (exp_cmd + 1) % 256;
      if (kind == K_LED) last_led = val;
      else               last_msg = val;
    end
    e.kind    = kind;
    e.val     = val;
    e.cmd     = exp_cmd;
    e.err     = exp_err;
    e.ref_idx = ref_idx;
    e.lat     = lat;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [7:0] op, input int v, input bit lower, input int kind);
    push_byte(op);
    push_byte(hex_char(v, lower));
    push_byte(CR);
    exp_push(kind, v, n_pushed - 1, 3);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_led_val"},   led_val,   last_led);
    check({tag, "_msg_sel"},   msg_sel,   last_msg);
    check({tag, "_err_code"},  err_code,  last_code);
    check({tag, "_cmd_count"}, cmd_count, exp_cmd);
    check({tag, "_err_count"}, err_count, exp_err);
  endtask

  // RX FIFO model: pop on a strobe seen before the edge, data valid after it.
  initial begin
    bit stb_seen;
    rd_data  = '0;
    rf_empty = 1'b1;
    forever begin
      @(negedge clk);
      stb_seen = (rd_stb === 1'b1);
      if (stb_seen) stb_cyc[pop_count] = cyc;
      @(posedge clk);
      #1;
      if (stb_seen && fifo_q.size() != 0) begin
        rd_data = fifo_q.pop_front();
        pop_count++;
      end
      rf_empty = (fifo_q.size() == 0);
    end
  end

  initial begin
    logic prev_stb;
    exp_t e;
    int   got_kind;
    int   got_val;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rd_stb) begin
          check("stb_b2b", prev_stb, 0);
          check("stb_empty", rf_empty, 0);
        end
        if (led_valid || msg_valid || err_pulse) begin
          check("valid_excl", led_valid & msg_valid, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {led_valid, msg_valid, err_pulse}, 0);
          end else begin
            e = exp_q.pop_front();
            got_kind = led_valid ? K_LED : (msg_valid ? K_MSG : K_ERR);
            got_val  = (got_kind == K_LED) ? int'(led_val) :
                       (got_kind == K_MSG) ? int'(msg_sel) : int'(err_code);
            check("pulse_kind", got_kind, e.kind);
            check("pulse_value", got_val, e.val);
            check("pulse_cmd_count", cmd_count, e.cmd);
            check("pulse_err_count", err_count, e.err);
            check("pulse_latency", cyc - stb_cyc[e.ref_idx], e.lat);
          end
        end
        prev_stb = rd_stb;
      end else begin
        prev_stb = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_stb", rd_stb, 0);
    check("rst_led_valid", led_valid, 0);
    check("rst_msg_valid", msg_valid, 0);
    check("rst_err_pulse", err_pulse, 0);
    check_regs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // L A CR from a preloaded FIFO, pops spaced two cycles apart
    idx = n_pushed;
    send_cmd("L", 10, 1'b0, K_LED);
    drain(100);
    check("t1_stb_gap0", stb_cyc[idx + 1] - stb_cyc[idx], 2);
    check("t1_stb_gap1", stb_cyc[idx + 2] - stb_cyc[idx + 1], 2);
    check_regs("t1");

    // m f LF CR, plus a bare CR and a lone LF as empty lines
    push_byte("m"); push_byte("f"); push_byte(LF); push_byte(CR);
    exp_push(K_MSG, 15, n_pushed - 1, 3);
    push_byte(CR); push_byte(LF);
    drain(100);
    check_regs("t2");

    // bad opcode discards the rest of its line; next line still works
    push_byte("X"); exp_push(K_ERR, E_BAD_OP, n_pushed - 1, 2);
    push_byte("1"); push_byte(CR);
    send_cmd("L", 3, 1'b0, K_LED);
    push_byte("Q"); exp_push(K_ERR, E_BAD_OP, n_pushed - 1, 2);
    push_byte("Q"); push_byte("Q"); push_byte(CR);
    drain(200);
    check_regs("t3");

    // too long, bad argument, missing argument, lowercase hex digit
    push_byte("L"); push_byte("5"); push_byte("5");
    exp_push(K_ERR, E_TOO_LONG, n_pushed - 1, 2);
    push_byte(CR);
    push_byte("L"); push_byte("G");
    exp_push(K_ERR, E_BAD_ARG, n_pushed - 1, 2);
    push_byte(CR);
    push_byte("l"); push_byte(CR);
    exp_push(K_ERR, E_BAD_ARG, n_pushed - 1, 2);
    drain(200);
    check_regs("t4");
    send_cmd("l", 11, 1'b1, K_LED);
    drain(100);
    check_regs("t4b");

    // slow bytes below the timeout keep the command alive
    push_byte("M"); repeat (15) @(negedge clk);
    push_byte("4"); repeat (15) @(negedge clk);
    push_byte(CR);
    exp_push(K_MSG, 4, n_pushed - 1, 3);
    drain(100);
    check_regs("t5");

    // timeout after a lone M, then a normal M command
    push_byte("M");
    exp_push(K_ERR, E_TIMEOUT, n_pushed - 1, 22);
    drain(200);
    check_regs("t6");
    send_cmd("M", 2, 1'b0, K_MSG);
    drain(100);
    check_regs("t6b");

    // err_count saturates at 255
    for (int i = 0; i < 256; i++) begin
      push_byte("Z");
      exp_push(K_ERR, E_BAD_OP, n_pushed - 1, 2);
      push_byte(CR);
    end
    drain(4000);
    check_regs("sat");

    // cmd_count wraps through 255 -> 0
    for (int i = 0; i < 256; i++) begin
      logic [7:0] op;
      if ((i % 2) == 0) op = ((i & 2) != 0) ? 8'h6C : 8'h4C;
      else              op = ((i & 2) != 0) ? 8'h6D : 8'h4D;
      send_cmd(op, i % 16, (i & 4) != 0, ((i % 2) == 0) ? K_LED : K_MSG);
    end
    drain(4000);
    check_regs("wrap");

    // reset with L 7 captured: nothing dispatched, CR becomes an empty line
    push_byte("L"); push_byte("7");
    for (int n = 0; n < 100 && pop_count != n_pushed; n++) @(negedge clk);
    check("mid_popped", pop_count, n_pushed);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = 0; exp_err = 0; last_led = 0; last_msg = 0; last_code = 0;
    check_regs("mid_rst");
    push_byte(CR);
    drain(100);
    check_regs("mid_after");
    send_cmd("L", 6, 1'b0, K_LED);
    drain(100);
    check_regs("mid_next");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
